// File: rtl/input_port_pkg.sv
// Shared definitions for the input-port front end: acknowledge FSM state
// encoding and the default word width of the datapath.
package input_port_pkg;

   // Default datapath word width
   localparam int DEF_DATA_W = 16;

   // Acknowledge FSM states (encoding kept fixed for legacy compatibility)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2
   } ack_state_t;

endpackage

// File: rtl/input_fifo.sv
// Circular-buffer FIFO for the input port. Occupancy is held in its own
// counter, so full/empty are decoded from registered state. A push while
// full is dropped unless a pop happens on the same edge (full is judged
// before the pop). `dropped` flags a rejected push for overrun accounting.
module input_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_en;
   logic              rd_en;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_en   = pop && !empty;
   assign wr_en   = push && (!full || rd_en);
   assign dropped = push && full && !rd_en;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Word storage; contents are only meaningful below the count, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/input_port_ctrl.sv
// Input-device front end: queues device words, requests service from the
// control FSM via InputRecv, and retires exactly one word per InputRst high
// interval into in_data. Optional overrun reporting (sticky flag plus a
// saturating drop counter) is enabled with `define INPUT_OVERRUN_EN.
module input_port_ctrl
   import input_port_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic                     dev_strobe,
   input  logic [DATA_W-1:0]        dev_data,
   input  logic                     InputRst,
   output logic                     InputRecv,
   output logic [DATA_W-1:0]        in_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     fifo_full
`ifdef INPUT_OVERRUN_EN
   ,
   output logic                     overrun,
   output logic [7:0]               drop_count
`endif
);

   ack_state_t        state;
   logic              pop;
   logic              empty;
   logic              dropped;
   logic [DATA_W-1:0] head;

   // Pop only from PEND, so a spurious or long-held acknowledge pops once
   assign pop       = (state == PEND) && InputRst;
   assign InputRecv = (state == PEND);

   input_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (CLK),
      .rst     (Reset),
      .push    (dev_strobe),
      .pop     (pop),
      .wdata   (dev_data),
      .rdata   (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (empty),
      .dropped (dropped)
   );

   // Acknowledge handshake: IDLE -> PEND on data, PEND -> ACK on ack, ACK -> IDLE on release
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (!empty)   state <= PEND;
            PEND:    if (InputRst) state <= ACK;
            ACK:     if (!InputRst) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Capture the head word on acknowledge and hold it for the handler
   always_ff @(posedge CLK) begin
      if (Reset)    in_data <= '0;
      else if (pop) in_data <= head;
   end

`ifdef INPUT_OVERRUN_EN
   // Sticky overrun flag and saturating count of dropped device words
   always_ff @(posedge CLK) begin
      if (Reset) begin
         overrun    <= 1'b0;
         drop_count <= 8'd0;
      end else if (dropped) begin
         overrun <= 1'b1;
         if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
   end
`else
   logic unused_dropped;
   assign unused_dropped = dropped;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl (DEPTH=4, DATA_W=16). Overrun checks
// are included when INPUT_OVERRUN_EN is defined.
module tb_input_port_ctrl;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        dev_strobe;
   logic [15:0] dev_data;
   logic        InputRst;
   logic        InputRecv;
   logic [15:0] in_data;
   logic [2:0]  fifo_count;
   logic        fifo_full;
`ifdef INPUT_OVERRUN_EN
   logic        overrun;
   logic [7:0]  drop_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   input_port_ctrl #(.DEPTH(4), .DATA_W(16)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .dev_strobe (dev_strobe),
      .dev_data   (dev_data),
      .InputRst   (InputRst),
      .InputRecv  (InputRecv),
      .in_data    (in_data),
      .fifo_count (fifo_count),
      .fifo_full  (fifo_full)
`ifdef INPUT_OVERRUN_EN
      ,
      .overrun    (overrun),
      .drop_count (drop_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Advance one rising edge, then settle 1 time unit before sampling/driving
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
   endtask

   // One full acknowledge: request must be up, data appears one edge after
   // InputRst rises, request re-appears two edges after InputRst falls if data remains
   task automatic ack(input logic [15:0] exp, input logic more);
      chk("ack_req", 32'(InputRecv), 32'd1);
      InputRst = 1'b1;
      step();
      chk("ack_data", 32'(in_data), 32'(exp));
      chk("ack_drop_req", 32'(InputRecv), 32'd0);
      InputRst = 1'b0;
      step();
      chk("ack_idle", 32'(InputRecv), 32'd0);
      step();
      chk("ack_rereq", 32'(InputRecv), 32'(more));
   endtask

   initial begin
      Reset      = 1'b1;
      dev_strobe = 1'b0;
      dev_data   = '0;
      InputRst   = 1'b0;
      step();
      step();
      Reset = 1'b0;
      step();

      // Reset state
      chk("rst_recv",  32'(InputRecv), 32'd0);
      chk("rst_data",  32'(in_data), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_full",  32'(fifo_full), 32'd0);
`ifdef INPUT_OVERRUN_EN
      chk("rst_ovr",   32'(overrun), 32'd0);
      chk("rst_drops", 32'(drop_count), 32'd0);
`endif

      // Single word, InputRst held for 3 cycles
      dev_strobe = 1'b1;
      dev_data   = 16'h1234;
      step();
      dev_strobe = 1'b0;
      chk("sw_count1", 32'(fifo_count), 32'd1);
      chk("sw_recv_early", 32'(InputRecv), 32'd0);
      step();
      chk("sw_recv", 32'(InputRecv), 32'd1);
      InputRst = 1'b1;
      step();
      chk("sw_data", 32'(in_data), 32'h1234);
      chk("sw_recv_drop", 32'(InputRecv), 32'd0);
      chk("sw_count0", 32'(fifo_count), 32'd0);
      step();
      step();
      chk("sw_hold_data", 32'(in_data), 32'h1234);
      chk("sw_hold_recv", 32'(InputRecv), 32'd0);
      InputRst = 1'b0;
      step();
      step();
      chk("sw_after_recv", 32'(InputRecv), 32'd0);

      // Spurious acknowledge in IDLE with empty FIFO
      InputRst = 1'b1;
      step();
      step();
      step();
      chk("sp_count", 32'(fifo_count), 32'd0);
      chk("sp_data", 32'(in_data), 32'h1234);
      chk("sp_recv", 32'(InputRecv), 32'd0);
      InputRst = 1'b0;
      step();

      // Fill and wrap: 0xA0..0xA5, last two dropped
      for (int i = 0; i < 6; i++) begin
         dev_strobe = 1'b1;
         dev_data   = 16'h00A0 + 16'(i);
         step();
      end
      dev_strobe = 1'b0;
      chk("fill_count", 32'(fifo_count), 32'd4);
      chk("fill_full", 32'(fifo_full), 32'd1);
`ifdef INPUT_OVERRUN_EN
      chk("fill_ovr", 32'(overrun), 32'd1);
      chk("fill_drops", 32'(drop_count), 32'd2);
`endif
      ack(16'h00A0, 1'b1);
      ack(16'h00A1, 1'b1);
      ack(16'h00A2, 1'b1);
      ack(16'h00A3, 1'b0);
      chk("fill_empty", 32'(fifo_count), 32'd0);

      // Simultaneous push and pop on a full FIFO
      do_reset();
      step();
      for (int i = 0; i < 4; i++) begin
         dev_strobe = 1'b1;
         dev_data   = 16'h00C0 + 16'(i);
         step();
      end
      dev_strobe = 1'b0;
      chk("sim_full", 32'(fifo_full), 32'd1);
      chk("sim_req", 32'(InputRecv), 32'd1);
      dev_strobe = 1'b1;
      dev_data   = 16'h00BB;
      InputRst   = 1'b1;
      step();
      dev_strobe = 1'b0;
      InputRst   = 1'b0;
      chk("sim_count", 32'(fifo_count), 32'd4);
      chk("sim_data", 32'(in_data), 32'h00C0);
`ifdef INPUT_OVERRUN_EN
      chk("sim_ovr", 32'(overrun), 32'd0);
`endif
      step();
      step();
      ack(16'h00C1, 1'b1);
      ack(16'h00C2, 1'b1);
      ack(16'h00C3, 1'b1);
      ack(16'h00BB, 1'b0);
      chk("sim_empty", 32'(fifo_count), 32'd0);

      // Reset mid-operation with InputRst high
      for (int i = 0; i < 3; i++) begin
         dev_strobe = 1'b1;
         dev_data   = 16'h00D0 + 16'(i);
         step();
      end
      dev_strobe = 1'b0;
      chk("mr_pend", 32'(InputRecv), 32'd1);
      InputRst = 1'b1;
      Reset    = 1'b1;
      step();
      Reset = 1'b0;
      chk("mr_count", 32'(fifo_count), 32'd0);
      chk("mr_recv", 32'(InputRecv), 32'd0);
      chk("mr_data", 32'(in_data), 32'd0);
      step();
      chk("mr_stay_idle", 32'(InputRecv), 32'd0);
      chk("mr_count2", 32'(fifo_count), 32'd0);
      dev_strobe = 1'b1;
      dev_data   = 16'h00E5;
      step();
      dev_strobe = 1'b0;
      step();
      chk("mr_repend", 32'(InputRecv), 32'd1);
      step();
      chk("mr_pop_data", 32'(in_data), 32'h00E5);
      chk("mr_pop_recv", 32'(InputRecv), 32'd0);
      InputRst = 1'b0;
      step();

      // Long overrun burst: 300 strobes, no acknowledges
      do_reset();
      dev_strobe = 1'b1;
      for (int i = 0; i < 300; i++) begin
         dev_data = 16'(i);
         step();
      end
      dev_strobe = 1'b0;
      chk("ob_count", 32'(fifo_count), 32'd4);
      chk("ob_full", 32'(fifo_full), 32'd1);
`ifdef INPUT_OVERRUN_EN
      chk("ob_ovr", 32'(overrun), 32'd1);
      chk("ob_drops", 32'(drop_count), 32'd255);
`endif
      ack(16'h0000, 1'b1);
      ack(16'h0001, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
